// File: rtl/rom_loader_if.sv
// Bundles the ioctl download port, the SDRAM slot strobe, the SDRAM write port and the loader status.
// The slave side is the loader; the master side is whatever drives the download and observes the writes.
interface rom_loader_if;
  logic        ce_ref;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        mem_we;
  logic [22:0] mem_addr;
  logic        mem_bank;
  logic [7:0]  mem_din;

  logic        busy;
  logic [7:0]  rom_valid;
  logic        overflow;
  logic [24:0] byte_count;

  modport master (
    output ce_ref, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  mem_we, mem_addr, mem_bank, mem_din, busy, rom_valid, overflow, byte_count
  );

  modport slave (
    input  ce_ref, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output mem_we, mem_addr, mem_bank, mem_din, busy, rom_valid, overflow, byte_count
  );
endinterface

// File: rtl/rom_loader.sv
// ROM download bridge: buffers ioctl bytes in a small FIFO, maps file offsets onto SDRAM pages/banks
// and commits one byte per ce_ref slot, holding the machine busy until every byte has landed.
module rom_loader #(
  parameter int FIFO_AW = 2
) (
  input  logic         clk_sys,
  input  logic         reset,
  rom_loader_if.slave  bus
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  typedef struct packed {
    logic        bank;
    logic [22:0] addr;
    logic [7:0]  data;
  } entry_t;

  // Slot selector s[1:0] to SDRAM page (mem_addr[22:14]) and back again.
  function automatic logic [8:0] page_of(input logic [1:0] sel);
    case (sel)
      2'd0:    page_of = 9'h000;
      2'd1:    page_of = 9'h100;
      2'd2:    page_of = 9'h107;
      default: page_of = 9'h1FF;
    endcase
  endfunction

  function automatic logic [1:0] sel_of(input logic [8:0] page);
    case (page)
      9'h100:  sel_of = 2'd1;
      9'h107:  sel_of = 2'd2;
      9'h1FF:  sel_of = 2'd3;
      default: sel_of = 2'd0;
    endcase
  endfunction

  logic               w_dl;
  logic               w_dl_rise;
  logic               w_accept;
  logic               w_empty;
  logic               w_full;
  logic               w_commit;
  logic               w_push;
  entry_t             w_new;
  entry_t             w_head;

  logic               r_dl_q;
  state_t             r_state;
  logic               r_first;
  logic [FIFO_AW:0]   r_wr_ptr;
  logic [FIFO_AW:0]   r_rd_ptr;
  entry_t             r_fifo [DEPTH];

  logic               r_mem_we;
  logic [22:0]        r_mem_addr;
  logic               r_mem_bank;
  logic [7:0]         r_mem_din;
  logic [7:0]         r_rom_valid;
  logic               r_overflow;
  logic [24:0]        r_byte_count;

  assign w_dl      = bus.ioctl_download & (bus.ioctl_index == 8'd0);
  assign w_dl_rise = w_dl & ~r_dl_q;
  assign w_accept  = w_dl & bus.ioctl_wr & (bus.ioctl_addr[24:17] == 8'd0);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

  // r_first marks the cycle mem_we rose; a ce_ref there is too early to commit.
  assign w_commit = (r_state == S_WRITE) & ~r_first & bus.ce_ref & ~w_dl_rise;
  assign w_push   = w_accept & (~w_full | w_commit | w_dl_rise);

  assign w_new.bank = bus.ioctl_addr[16];
  assign w_new.addr = {page_of(bus.ioctl_addr[15:14]), bus.ioctl_addr[13:0]};
  assign w_new.data = bus.ioctl_dout;

  assign w_head = r_fifo[r_rd_ptr[FIFO_AW-1:0]];

  // NOTE: the FIFO storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      if (w_dl_rise) r_fifo[0] <= w_new;
      else           r_fifo[r_wr_ptr[FIFO_AW-1:0]] <= w_new;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_dl_rise) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= w_push ? (FIFO_AW+1)'(1) : '0;
    end else begin
      if (w_commit) r_rd_ptr <= r_rd_ptr + (FIFO_AW+1)'(1);
      if (w_push)   r_wr_ptr <= r_wr_ptr + (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dl_q       <= 1'b0;
      r_state      <= S_IDLE;
      r_first      <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_bank   <= 1'b0;
      r_mem_din    <= '0;
      r_rom_valid  <= '0;
      r_overflow   <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_dl_q <= w_dl;
      if (w_dl_rise) begin
        r_state      <= S_IDLE;
        r_first      <= 1'b0;
        r_mem_we     <= 1'b0;
        r_rom_valid  <= '0;
        r_overflow   <= 1'b0;
        r_byte_count <= '0;
      end else begin
        if (w_accept && !w_push) r_overflow <= 1'b1;
        case (r_state)
          S_IDLE: begin
            if (!w_empty) begin
              r_mem_addr <= w_head.addr;
              r_mem_bank <= w_head.bank;
              r_mem_din  <= w_head.data;
              r_mem_we   <= 1'b1;
              r_first    <= 1'b1;
              r_state    <= S_WRITE;
            end
          end
          S_WRITE: begin
            r_first <= 1'b0;
            if (w_commit) begin
              r_mem_we <= 1'b0;
              r_state  <= S_IDLE;
              if (r_byte_count != '1) r_byte_count <= r_byte_count + 25'd1;
              if (r_mem_addr[13:0] == 14'h3FFF)
                r_rom_valid[{r_mem_bank, sel_of(r_mem_addr[22:14])}] <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Reset also masks the live download request so busy reads 0 while reset is held.
  assign bus.busy       = (w_dl & ~reset) | ~w_empty | r_mem_we;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_bank   = r_mem_bank;
  assign bus.mem_din    = r_mem_din;
  assign bus.rom_valid  = r_rom_valid;
  assign bus.overflow   = r_overflow;
  assign bus.byte_count = r_byte_count;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: a queue-based model of the download checked every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_rom_loader;

  localparam int DEPTH = 4;

  logic clk_sys = 1'b0;
  logic reset   = 1'b0;

  rom_loader_if bus ();

  rom_loader #(.FIFO_AW(2)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ce_ref: one cycle in sixteen, updated just after the rising edge.
  int ce_cnt = 0;
  initial begin
    bus.ce_ref = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      ce_cnt = (ce_cnt + 1) % 16;
      bus.ce_ref = (ce_cnt == 15);
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        bank;
    logic [22:0] addr;
    logic [7:0]  data;
    logic [2:0]  slot;
  } exp_t;

  exp_t        q[$];
  logic [8:0]  page_tbl [4] = '{9'h000, 9'h100, 9'h107, 9'h1FF};
  logic [24:0] m_count;
  logic [7:0]  m_valid;
  logic        m_ovf;
  logic        m_dl_q;
  logic        m_prev_we;
  logic        m_drop;
  int          we_len;

  always @(negedge clk_sys) begin
    logic dl;
    logic rise;
    logic commit;
    exp_t e;
    if (reset) begin
      chk("rst_mem_we",   bus.mem_we, 0);
      chk("rst_busy",     bus.busy, 0);
      chk("rst_count",    bus.byte_count, 0);
      chk("rst_overflow", bus.overflow, 0);
      q.delete();
      m_count = '0; m_valid = '0; m_ovf = 1'b0;
      m_dl_q = 1'b0; m_prev_we = 1'b0; m_drop = 1'b0; we_len = 0;
    end else begin
      dl = bus.ioctl_download && (bus.ioctl_index == 8'd0);
      if (m_drop) chk("we_drop", bus.mem_we, 0);
      if (bus.mem_we) begin
        chk("we_has_data", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          chk("wr_addr", bus.mem_addr, q[0].addr);
          chk("wr_bank", bus.mem_bank, q[0].bank);
          chk("wr_data", bus.mem_din,  q[0].data);
        end
        we_len++;
        if (we_len > 17) chk("we_len_max", we_len, 17);
      end else begin
        we_len = 0;
      end
      chk("busy",       bus.busy, 32'(dl || (q.size() != 0)));
      chk("byte_count", bus.byte_count, m_count);
      chk("overflow",   bus.overflow, m_ovf);
      chk("rom_valid",  bus.rom_valid, m_valid);

      rise   = dl && !m_dl_q;
      commit = bus.mem_we && m_prev_we && bus.ce_ref && !rise;
      m_drop = commit || (rise && bus.mem_we);
      if (rise) begin
        q.delete();
        m_count = '0; m_valid = '0; m_ovf = 1'b0;
      end
      if (commit && q.size() != 0) begin
        e = q.pop_front();
        if (m_count != 25'h1FFFFFF) m_count = m_count + 25'd1;
        if (e.addr[13:0] == 14'h3FFF) m_valid[e.slot] = 1'b1;
      end
      if (dl && bus.ioctl_wr && (bus.ioctl_addr < 25'h20000)) begin
        if (q.size() < DEPTH) begin
          e.slot = bus.ioctl_addr[16:14];
          e.bank = e.slot[2];
          e.addr = 23'(page_tbl[e.slot[1:0]] * 23'h4000 + 23'(bus.ioctl_addr[13:0]));
          e.data = bus.ioctl_dout;
          q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_dl_q    = dl;
      m_prev_we = bus.mem_we;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic put(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    step();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic begin_dl(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    step();
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    step();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 2000) begin
      step();
      n++;
    end
    chk(name, bus.busy, 0);
  endtask

  task automatic wait_count(input string name, input logic [24:0] tgt);
    int n = 0;
    while (bus.byte_count != tgt && n < 500) begin
      step();
      n++;
    end
    chk(name, bus.byte_count, tgt);
  endtask

  task automatic wait_we(input string name);
    int n = 0;
    while (!bus.mem_we && n < 50) begin
      step();
      n++;
    end
    chk(name, bus.mem_we, 1);
  endtask

  task automatic wait_ce();
    int n = 0;
    while (!bus.ce_ref && n < 20) begin
      step();
      n++;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int len;
    logic [24:0] a;

    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    #1 reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("idle_busy", bus.busy, 0);

    // Slot 0 stream: first and last 128 bytes of the 16 KiB page, one strobe per 32 cycles.
    begin_dl(8'd0);
    for (int i = 0; i < 256; i++) begin
      a = (i < 128) ? 25'(i) : 25'(32'h3F00 + i);
      put(a, 8'(i) ^ 8'h5A);
      repeat (31) step();
    end
    end_dl();
    wait_idle("stream_drain");
    chk("stream_count", bus.byte_count, 256);
    chk("stream_valid", bus.rom_valid, 8'h01);
    chk("stream_ovf",   bus.overflow, 0);
    chk("stream_last_addr", bus.mem_addr, 23'h003FFF);
    chk("stream_last_din",  bus.mem_din, 8'hA5);

    // Page/bank mapping of slots 7 and 2, then discarded strobes.
    begin_dl(8'd0);
    chk("new_dl_count", bus.byte_count, 0);
    chk("new_dl_valid", bus.rom_valid, 0);
    put(25'h1C005, 8'h11);
    wait_we("slot7_we");
    chk("slot7_bank", bus.mem_bank, 1);
    chk("slot7_addr", bus.mem_addr, 23'h7FC005);
    chk("slot7_din",  bus.mem_din, 8'h11);
    wait_count("slot7_commit", 25'd1);
    put(25'h08123, 8'h22);
    wait_we("slot2_we");
    chk("slot2_bank", bus.mem_bank, 0);
    chk("slot2_addr", bus.mem_addr, 23'h41C123);
    wait_count("slot2_commit", 25'd2);
    put(25'h20000, 8'h33);
    put(25'h1FFFFFF, 8'h44);
    repeat (40) step();
    chk("oob_count", bus.byte_count, 2);
    chk("oob_ovf",   bus.overflow, 0);
    bus.ioctl_index = 8'd1;
    step();
    put(25'h00001, 8'h55);
    put(25'h00002, 8'h66);
    repeat (40) step();
    chk("idx1_count", bus.byte_count, 2);
    chk("idx1_we",    bus.mem_we, 0);
    end_dl();

    // Six back-to-back strobes into a four-entry FIFO, started right after a ce_ref.
    begin_dl(8'd0);
    wait_ce();
    for (int k = 0; k < 6; k++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(32'h100 + k);
      bus.ioctl_dout = 8'(8'hC0 + k);
      step();
    end
    bus.ioctl_wr = 1'b0;
    wait_count("burst_count", 25'd4);
    repeat (40) step();
    chk("burst_count_final", bus.byte_count, 4);
    chk("burst_ovf", bus.overflow, 1);

    // mem_we rising in a ce_ref cycle must wait for the next slot: high for 17 cycles.
    while (ce_cnt != 13) step();
    put(25'h00200, 8'h99);
    step();
    chk("align_we_rise", bus.mem_we, 1);
    chk("align_ce_same", bus.ce_ref, 1);
    len = 1;
    while (bus.mem_we && len < 40) begin
      step();
      len++;
    end
    chk("align_we_len", len - 1, 17);
    chk("align_count", bus.byte_count, 5);

    // Reset with a write in flight and three entries behind it.
    wait_ce();
    for (int k = 0; k < 4; k++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(32'h300 + k);
      bus.ioctl_dout = 8'(k + 1);
      step();
    end
    bus.ioctl_wr = 1'b0;
    chk("pre_rst_we", bus.mem_we, 1);
    bus.ioctl_download = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_now_we",    bus.mem_we, 0);
    chk("rst_now_addr",  bus.mem_addr, 0);
    chk("rst_now_bank",  bus.mem_bank, 0);
    chk("rst_now_din",   bus.mem_din, 0);
    chk("rst_now_busy",  bus.busy, 0);
    chk("rst_now_valid", bus.rom_valid, 0);
    chk("rst_now_ovf",   bus.overflow, 0);
    chk("rst_now_count", bus.byte_count, 0);
    step();
    step();
    reset = 1'b0;
    repeat (40) step();
    chk("post_rst_we",    bus.mem_we, 0);
    chk("post_rst_count", bus.byte_count, 0);

    // Download restarted while the FIFO is still draining.
    begin_dl(8'd0);
    put(25'h13FFF, 8'h77);
    wait_count("slot4_commit", 25'd1);
    chk("slot4_valid", bus.rom_valid, 8'h10);
    wait_ce();
    for (int k = 0; k < 4; k++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(32'h10 + k);
      bus.ioctl_dout = 8'(8'hE0 + k);
      step();
    end
    bus.ioctl_wr = 1'b0;
    end_dl();
    step();
    chk("drain_busy", bus.busy, 1);
    bus.ioctl_download = 1'b1;
    step();
    chk("flush_count", bus.byte_count, 0);
    chk("flush_valid", bus.rom_valid, 0);
    chk("flush_ovf",   bus.overflow, 0);
    end_dl();
    wait_idle("flush_drain");
    repeat (20) step();
    chk("flush_no_writes", bus.byte_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
